// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART TX scheduler.
// Holds the FSM encoding and requester ids used by the top and the bench.
package uart_tx_sched_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Parallel-load port between the scheduler and the UART transmitter.
// master drives data/strobe, slave returns the busy flag.
interface uart_tx_sched_if
    import uart_tx_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic [DATA_W-1:0] tx_p_data;
    logic              tx_data_valid;
    logic              tx_busy;

    modport master (
        output tx_p_data,
        output tx_data_valid,
        input  tx_busy
    );

    modport slave (
        input  tx_p_data,
        input  tx_data_valid,
        output tx_busy
    );

endinterface

// File: rtl/uart_tx_sched_slot.sv
// uart_req_slot: single-entry request capture with sticky overflow.
// A free in the same cycle as a new request lets the request in.
module uart_req_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_i,
    input  logic         valid_i,
    input  logic         free_i,
    output logic         pend_o,
    output logic [W-1:0] data_o,
    output logic         ovf_o
);

    logic         pend_q, pend_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        pend_d = pend_q & ~free_i;
        ovf_d  = ovf_q;
        data_d = data_q;
        if (valid_i) begin
            if (pend_d) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = 1'b1;
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            data_q <= data_d;
        end
    end

    assign pend_o = pend_q;
    assign data_o = data_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler of two requesters onto one UART transmitter.
// Optional busy timeout: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TO_CYC = 1024,
    parameter int TO_W   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                a_valid,
    input  logic [2*DATA_W-1:0] b_data,
    input  logic                b_valid,
    output logic                a_pend,
    output logic                b_pend,
    uart_tx_sched_if.master     tx,
    output logic                ovf,
    output logic                to_err
);

    if (2 ** TO_W < TO_CYC) begin : g_bad_to
        $error("TO_W too narrow for TO_CYC");
    end

    state_t              state_q;
    logic                ptr_q, gnt_q, idx_q;
    logic                dv_q;
    logic [DATA_W-1:0]   dat_q;
    logic [DATA_W-1:0]   a_byte;
    logic [2*DATA_W-1:0] b_word;
    logic                ovf_a, ovf_b;
    logic                gnt_c, last, done;
    logic                free_a, free_b, to_hit;

    assign gnt_c  = (a_pend && b_pend) ? ptr_q :
                    (a_pend ? REQ_A : REQ_B);
    assign last   = (gnt_q == REQ_A) || idx_q;
    assign done   = (state_q == WAIT_DONE) && !tx.tx_busy && last;
    assign free_a = (done || to_hit) && (gnt_q == REQ_A);
    assign free_b = (done || to_hit) && (gnt_q == REQ_B);

    uart_req_slot #(.W(DATA_W)) u_slot_a (
        .clk     (clk),
        .rst     (rst),
        .data_i  (a_data),
        .valid_i (a_valid),
        .free_i  (free_a),
        .pend_o  (a_pend),
        .data_o  (a_byte),
        .ovf_o   (ovf_a)
    );

    uart_req_slot #(.W(2*DATA_W)) u_slot_b (
        .clk     (clk),
        .rst     (rst),
        .data_i  (b_data),
        .valid_i (b_valid),
        .free_i  (free_b),
        .pend_o  (b_pend),
        .data_o  (b_word),
        .ovf_o   (ovf_b)
    );

    assign ovf              = ovf_a | ovf_b;
    assign tx.tx_data_valid = dv_q;
    assign tx.tx_p_data     = dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= REQ_A;
            gnt_q   <= REQ_A;
            idx_q   <= 1'b0;
            dv_q    <= 1'b0;
            dat_q   <= '0;
        end else begin
            dv_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if ((a_pend || b_pend) && !tx.tx_busy) begin
                        gnt_q   <= gnt_c;
                        idx_q   <= 1'b0;
                        dv_q    <= 1'b1;
                        dat_q   <= (gnt_c == REQ_A) ? a_byte
                                                    : b_word[DATA_W-1:0];
                        state_q <= LOAD;
                        if (a_pend && b_pend) ptr_q <= ~ptr_q;
                    end
                end
                LOAD: state_q <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (tx.tx_busy) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx.tx_busy) begin
                        if (last) begin
                            state_q <= IDLE;
                        end else begin
                            // B's MSB follows directly; no re-arbitration
                            idx_q   <= 1'b1;
                            dv_q    <= 1'b1;
                            dat_q   <= b_word[2*DATA_W-1:DATA_W];
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (to_hit) begin
                state_q <= IDLE;
                dv_q    <= 1'b0;
            end
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] to_q;
    logic            to_err_q;

    assign to_hit = ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE))
                    && (to_q == TO_W'(TO_CYC - 1));
    assign to_err = to_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_q     <= '0;
            to_err_q <= 1'b0;
        end else begin
            if (to_hit) to_err_q <= 1'b1;
            if (state_q == LOAD ||
                (state_q == WAIT_BUSY && tx.tx_busy))
                to_q <= '0;
            else
                to_q <= to_q + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
    assign to_err = 1'b0;
`endif

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Schedules the shared UART transmitter between two byte-oriented requesters.
  - Requester A: register-file read data, 1 byte per request.
  - Requester B: ALU result, 2 bytes per request, LSB first.
- Captures each request into a single-entry slot and arbitrates round-robin between slots.
- Drives the transmitter's parallel data / data-valid inputs and sequences on its busy flag so that no byte is issued while a frame is in flight.
- Sits in the reference clock domain, ahead of the TX clock-domain crossing.

Parameters:
- DATA_W, 8, width of one UART byte.
- TO_CYC, 1024, busy-timeout in clk cycles (used only with the optional feature).
- TO_W, 10, width of the timeout counter; must satisfy 2**TO_W >= TO_CYC.

Ports:
- clk  in  1  block clock; one clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- a_data  in  DATA_W  requester A byte.
- a_valid  in  1  requester A one-cycle request pulse.
- b_data  in  2*DATA_W  requester B word.
- b_valid  in  1  requester B one-cycle request pulse.
- a_pend  out  1  slot A occupied.
- b_pend  out  1  slot B occupied.
- tx_p_data  out  DATA_W  byte to the UART transmitter.
- tx_data_valid  out  1  one-cycle load strobe to the transmitter.
- tx_busy  in  1  transmitter busy; already synchronized into clk.
- ovf  out  1  sticky: a request arrived while its slot was occupied.
- to_err  out  1  sticky busy-timeout flag (optional feature; otherwise tied 0).

Behaviour:
- Reset:
  - All outputs are 0.
  - Both slots are empty.
  - FSM is in IDLE.
  - Round-robin pointer points to A.
- Capture:
  - x_valid=1 with slot x empty: data latched, x_pend=1 on the next cycle.
  - x_valid=1 with slot x full: request dropped, slot unchanged, ovf=1 from the next cycle until reset.
  - A slot is freed in the same cycle its last byte's WAIT_DONE completes. A new x_valid in that same cycle is captured, not an overflow.
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
  - IDLE:
    - Stays if no slot is pending or tx_busy=1.
    - Otherwise grants a slot:
      - Only one slot pending: grant it.
      - Both pending: grant the one the pointer selects, then toggle the pointer to the other slot.
    - Byte index is set to 0.
    - Goes to LOAD.
  - LOAD, exactly 1 cycle:
    - tx_data_valid=1.
    - tx_p_data = A byte, or B[7:0] (index 0) / B[15:8] (index 1).
    - Goes to WAIT_BUSY.
  - WAIT_BUSY:
    - tx_p_data is held stable.
    - Leaves when tx_busy=1 → WAIT_DONE.
  - WAIT_DONE:
    - Leaves when tx_busy=0.
    - Granted slot is A, or B at index 1: free the slot, go to IDLE.
    - Granted slot is B at index 0: index=1, go directly to LOAD. Slot B is not re-arbitrated, so B's two bytes are never split.
- Latency: from a_valid with an idle transmitter, tx_data_valid is asserted 2 cycles later (capture, IDLE, then LOAD).
- tx_p_data: holds its last value outside LOAD/WAIT_*; it is 0 only after reset.
- Both requests in the same cycle, both slots empty, pointer=A: A is transmitted first, then B LSB, then B MSB.
- tx_busy already 1 in IDLE (e.g. after reset): no grant until it falls.
- Reset mid-operation:
  - Pending slots are discarded and the FSM returns to IDLE.
  - An in-flight frame in the transmitter is not aborted.

Optional Feature:
- Macro: UART_TX_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_BUSY and WAIT_DONE and increments each cycle spent in either state.
  - On reaching TO_CYC-1:
    - to_err is set (sticky until reset).
    - The granted slot is freed (both B bytes are abandoned).
    - The pointer is unchanged.
    - The FSM returns to IDLE.
- Undefined:
  - No counter is built; to_err is constant 0.
  - WAIT states wait indefinitely.

Decomposition:
- Shared package holds:
  - the FSM state encoding (2-bit enum IDLE/LOAD/WAIT_BUSY/WAIT_DONE);
  - the requester id constants REQ_A=0, REQ_B=1;
  - the DATA_W default.
- One sub-module, uart_req_slot: a single-entry capture register with valid/free/overflow logic.
  - Instantiated twice, parameterised by width (DATA_W and 2*DATA_W).
- Arbiter and FSM stay in the top module.

Test Plan:
- a_valid with a_data=0x5A; transmitter model raises busy 2 cycles after the strobe and drops it 10 cycles later:
  - expected: one tx_data_valid pulse with 0x5A;
  - expected: a_pend clears when busy falls.
- b_valid with b_data=0xBEEF:
  - expected: strobes carry 0xEF then 0xBE;
  - expected: the second strobe comes the cycle after busy falls (no return to IDLE).
- a_valid=0x11 and b_valid=0x2233 in the same cycle; then both re-requested:
  - expected first pass: 0x11, 0x33, 0x22;
  - expected second pass: 0x33, 0x22, 0x11 (round-robin).
- a_valid twice while A is pending:
  - expected: the second request is dropped and ovf=1 persists;
  - expected: only the first byte is transmitted.
- rst pulse during WAIT_DONE of B index 0:
  - expected: all outputs 0 the cycle after;
  - expected: the MSB is never strobed.
- With UART_TX_SCHED_TIMEOUT_EN and TO_CYC=16, busy held at 0 after the strobe:
  - expected: to_err=1 after 16 cycles in WAIT_BUSY;
  - expected: the slot is freed and the FSM is back in IDLE.
